counter_pwm_compare: RTL and testbench

- Downstream consumer of the 8-bit loadable counter (out/cout).
- Compares the live count against a double-buffered duty value to produce a registered PWM output.
- Counts counter wrap pulses (cout) into a period counter and raises a sticky interrupt after a programmable number of periods, with an ack handshake.
- Duty updates are glitch-free: they take effect only at a counter wrap.

---
 rtl/counter_pwm_compare.sv | 94 +++++++++
 tb/tb_counter_pwm_compare.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_pwm_compare.sv
// ============================================================================
// counter_pwm_compare: double-buffered PWM compare and period interrupt
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter_pwm_compare #(
   parameter int WIDTH = 8,
   parameter int PER_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             cnt_cout,
   input  logic [WIDTH-1:0] duty_in,
   input  logic             duty_wr,
   output logic             duty_pend,
   output logic             duty_ack,
   input  logic [PER_W-1:0] per_thresh,
   output logic [PER_W-1:0] per_count,
   output logic             irq,
   output logic             irq_ovf,
   input  logic             irq_ack,
   output logic             pwm_out
);

   logic [WIDTH-1:0] r_duty_shadow;
   logic [WIDTH-1:0] r_duty_active;
   logic [PER_W-1:0] w_per_next;
   logic             w_thresh_hit;

   assign w_per_next   = per_count + PER_W'(1);
   assign w_thresh_hit = cnt_cout && (per_thresh != '0) && (w_per_next == per_thresh);

   // A write coinciding with a wrap bypasses the shadow so it is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_duty_shadow <= '0;
         r_duty_active <= '0;
         duty_pend     <= 1'b0;
         duty_ack      <= 1'b0;
      end else if (duty_wr && cnt_cout) begin
         r_duty_shadow <= duty_in;
         r_duty_active <= duty_in;
         duty_pend     <= 1'b0;
         duty_ack      <= 1'b1;
      end else if (duty_wr) begin
         r_duty_shadow <= duty_in;
         duty_pend     <= 1'b1;
         duty_ack      <= 1'b0;
      end else if (cnt_cout && duty_pend) begin
         r_duty_active <= r_duty_shadow;
         duty_pend     <= 1'b0;
         duty_ack      <= 1'b1;
      end else begin
         duty_ack      <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= (cnt_in < r_duty_active);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         per_count <= '0;
      end else if (w_thresh_hit) begin
         per_count <= '0;
      end else if (cnt_cout) begin
         per_count <= w_per_next;
      end
   end

   // Set beats ack; overflow records a second event while irq is still unacked.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq     <= 1'b0;
         irq_ovf <= 1'b0;
      end else if (w_thresh_hit) begin
         irq     <= 1'b1;
         irq_ovf <= irq_ack ? 1'b0 : (irq_ovf | irq);
      end else if (irq_ack) begin
         irq     <= 1'b0;
         irq_ovf <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_counter_pwm_compare.sv
// ============================================================================
// tb_counter_pwm_compare: vector table, directed sequences and random run
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_counter_pwm_compare;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] cnt_in = '0;
   logic       cnt_cout = 1'b0;
   logic [7:0] duty_in = '0;
   logic       duty_wr = 1'b0;
   logic       duty_pend;
   logic       duty_ack;
   logic [7:0] per_thresh = '0;
   logic [7:0] per_count;
   logic       irq;
   logic       irq_ovf;
   logic       irq_ack = 1'b0;
   logic       pwm_out;

   counter_pwm_compare #(.WIDTH(8), .PER_W(8)) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_cout(cnt_cout),
      .duty_in(duty_in), .duty_wr(duty_wr), .duty_pend(duty_pend),
      .duty_ack(duty_ack), .per_thresh(per_thresh), .per_count(per_count),
      .irq(irq), .irq_ovf(irq_ovf), .irq_ack(irq_ack), .pwm_out(pwm_out)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int m_shadow = 0, m_active = 0, m_per = 0;
   bit m_pend = 0, m_dack = 0, m_irq = 0, m_ovf = 0, m_pwm = 0;

   logic [7:0] tb_cnt = '0;

   typedef struct {
      bit   rst;
      logic [7:0] cnt;
      bit   cout;
      logic [7:0] duty;
      bit   wr;
      logic [7:0] thresh;
      bit   ack;
      bit   e_pwm, e_pend, e_dack, e_irq, e_ovf;
      logic [7:0] e_per;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      bit ev;
      if (rst) begin
         m_shadow = 0; m_active = 0; m_per = 0;
         m_pend = 0; m_dack = 0; m_irq = 0; m_ovf = 0; m_pwm = 0;
      end else begin
         m_pwm = (int'(cnt_in) < m_active);
         m_dack = 0;
         if (duty_wr && cnt_cout) begin
            m_active = duty_in; m_shadow = duty_in; m_pend = 0; m_dack = 1;
         end else if (duty_wr) begin
            m_shadow = duty_in; m_pend = 1;
         end else if (cnt_cout && m_pend) begin
            m_active = m_shadow; m_pend = 0; m_dack = 1;
         end
         ev = 0;
         if (cnt_cout) begin
            if (per_thresh != 0 && ((m_per + 1) % 256) == int'(per_thresh)) begin
               m_per = 0; ev = 1;
            end else begin
               m_per = (m_per + 1) % 256;
            end
         end
         if (ev) begin
            m_ovf = irq_ack ? 1'b0 : (m_ovf | m_irq);
            m_irq = 1;
         end else if (irq_ack) begin
            m_irq = 0; m_ovf = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic check_model();
      chk("pwm_out", pwm_out, m_pwm);
      chk("duty_pend", duty_pend, m_pend);
      chk("duty_ack", duty_ack, m_dack);
      chk("irq", irq, m_irq);
      chk("irq_ovf", irq_ovf, m_ovf);
      chk("per_count", per_count, m_per);
   endtask

   task automatic run_cycle(input bit glitch);
      cnt_in   = tb_cnt;
      cnt_cout = (tb_cnt == 8'hFF) || glitch;
      step();
      check_model();
      tb_cnt = tb_cnt + 8'd1;
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle(1'b0);
   endtask

   task automatic write_and_measure(input logic [7:0] d, input int exp_high);
      int high;
      duty_in = d; duty_wr = 1'b1;
      run_cycle(1'b0);
      duty_wr = 1'b0;
      chk("pend_after_write", duty_pend, 1'b1);
      for (int i = 0; i < 256 && tb_cnt != 8'h00; i++) run_cycle(1'b0);
      chk("ack_after_wrap", duty_ack, 1'b1);
      chk("pend_after_wrap", duty_pend, 1'b0);
      high = 0;
      for (int i = 0; i < 256; i++) begin
         run_cycle(1'b0);
         if (i == 0) chk("ack_one_cycle", duty_ack, 1'b0);
         if (pwm_out) high++;
      end
      chk("pwm_high_cycles", high, exp_high);
   endtask

   initial begin
      int high;
      logic [7:0] per0;

      //            rst cnt    co duty   wr thr    ak pwm pnd dak irq ovf per
      vecs[0]  = '{1, 8'h00, 0, 8'h00, 0, 8'd0, 0, 0, 0, 0, 0, 0, 8'd0};
      vecs[1]  = '{0, 8'h10, 0, 8'h80, 1, 8'd2, 0, 0, 1, 0, 0, 0, 8'd0};
      vecs[2]  = '{0, 8'h20, 0, 8'h00, 0, 8'd2, 0, 0, 1, 0, 0, 0, 8'd0};
      vecs[3]  = '{0, 8'hFF, 1, 8'h00, 0, 8'd2, 0, 0, 0, 1, 0, 0, 8'd1};
      vecs[4]  = '{0, 8'h00, 0, 8'h00, 0, 8'd2, 0, 1, 0, 0, 0, 0, 8'd1};
      vecs[5]  = '{0, 8'h7F, 0, 8'h00, 0, 8'd2, 0, 1, 0, 0, 0, 0, 8'd1};
      vecs[6]  = '{0, 8'h80, 0, 8'h00, 0, 8'd2, 0, 0, 0, 0, 0, 0, 8'd1};
      vecs[7]  = '{0, 8'hFF, 1, 8'h00, 0, 8'd2, 0, 0, 0, 0, 1, 0, 8'd0};
      vecs[8]  = '{0, 8'h00, 1, 8'h05, 1, 8'd2, 0, 1, 0, 1, 1, 0, 8'd1};
      vecs[9]  = '{0, 8'h04, 1, 8'h00, 0, 8'd2, 0, 1, 0, 0, 1, 1, 8'd0};
      vecs[10] = '{0, 8'h05, 0, 8'h00, 0, 8'd2, 1, 0, 0, 0, 0, 0, 8'd0};
      vecs[11] = '{0, 8'hFF, 1, 8'h00, 0, 8'd2, 1, 0, 0, 0, 0, 0, 8'd1};
      vecs[12] = '{0, 8'hFF, 1, 8'h00, 0, 8'd2, 1, 0, 0, 0, 1, 0, 8'd0};
      vecs[13] = '{0, 8'hFF, 1, 8'h00, 0, 8'd2, 1, 0, 0, 0, 0, 0, 8'd1};
      vecs[14] = '{0, 8'hFF, 1, 8'h00, 0, 8'd2, 0, 0, 0, 0, 1, 0, 8'd0};
      vecs[15] = '{0, 8'h00, 1, 8'h00, 0, 8'd2, 0, 1, 0, 0, 1, 0, 8'd1};
      vecs[16] = '{0, 8'h00, 1, 8'h00, 0, 8'd2, 1, 1, 0, 0, 1, 0, 8'd0};
      vecs[17] = '{0, 8'h00, 1, 8'h00, 0, 8'd0, 0, 1, 0, 0, 1, 0, 8'd1};
      vecs[18] = '{1, 8'h00, 0, 8'h33, 1, 8'd0, 0, 0, 0, 0, 0, 0, 8'd0};

      rst = 1'b1;
      step();
      for (int i = 0; i < 19; i++) begin
         rst = vecs[i].rst; cnt_in = vecs[i].cnt; cnt_cout = vecs[i].cout;
         duty_in = vecs[i].duty; duty_wr = vecs[i].wr;
         per_thresh = vecs[i].thresh; irq_ack = vecs[i].ack;
         step();
         chk($sformatf("vec%0d_pwm", i), pwm_out, vecs[i].e_pwm);
         chk($sformatf("vec%0d_pend", i), duty_pend, vecs[i].e_pend);
         chk($sformatf("vec%0d_dack", i), duty_ack, vecs[i].e_dack);
         chk($sformatf("vec%0d_irq", i), irq, vecs[i].e_irq);
         chk($sformatf("vec%0d_ovf", i), irq_ovf, vecs[i].e_ovf);
         chk($sformatf("vec%0d_per", i), per_count, vecs[i].e_per);
      end

      // Idle: free-running counter, no writes, interrupt disabled
      rst = 1'b0; duty_wr = 1'b0; irq_ack = 1'b0; per_thresh = 8'd0;
      tb_cnt = 8'h00;
      run_n(512);
      chk("idle_per_count", per_count, 8'd2);

      // Duty write mid-period, overwrite, and boundary duties
      tb_cnt = 8'h80;
      run_n(1);
      write_and_measure(8'h40, 64);
      tb_cnt = 8'h30;
      duty_in = 8'h10; duty_wr = 1'b1;
      run_cycle(1'b0);
      duty_wr = 1'b0;
      run_n(5);
      write_and_measure(8'hF0, 240);
      write_and_measure(8'h00, 0);
      write_and_measure(8'hFF, 255);

      // Write coinciding with the wrap goes straight to active
      while (tb_cnt != 8'hFF) run_cycle(1'b0);
      duty_in = 8'h40; duty_wr = 1'b1;
      run_cycle(1'b0);
      duty_wr = 1'b0;
      chk("coincident_pend", duty_pend, 1'b0);
      chk("coincident_ack", duty_ack, 1'b1);
      high = 0;
      for (int i = 0; i < 256; i++) begin
         run_cycle(1'b0);
         if (pwm_out) high++;
      end
      chk("coincident_pwm_high", high, 64);

      // Counter load to F0 with duty F8
      write_and_measure(8'hF8, 248);
      run_n(16);
      tb_cnt = 8'hF0;
      per0 = per_count;
      high = 0;
      for (int i = 0; i < 16; i++) begin
         run_cycle(1'b0);
         if (pwm_out) high++;
      end
      chk("load_pwm_high", high, 8);
      chk("load_one_wrap", per_count, per0 + 8'd1);

      // Interrupt threshold, overflow, ack collision
      rst = 1'b1;
      step();
      check_model();
      rst = 1'b0;
      per_thresh = 8'd3;
      tb_cnt = 8'h00;
      run_n(768);
      chk("thr_irq", irq, 1'b1);
      chk("thr_per_zero", per_count, 8'd0);
      chk("thr_no_ovf", irq_ovf, 1'b0);
      run_n(768);
      chk("thr_irq_still", irq, 1'b1);
      chk("thr_ovf", irq_ovf, 1'b1);
      run_n(767);
      irq_ack = 1'b1;
      run_cycle(1'b0);
      irq_ack = 1'b0;
      chk("collide_irq", irq, 1'b1);
      chk("collide_ovf", irq_ovf, 1'b0);
      irq_ack = 1'b1;
      run_cycle(1'b0);
      irq_ack = 1'b0;
      chk("ack_irq", irq, 1'b0);
      chk("ack_ovf", irq_ovf, 1'b0);

      // Randomized run against the model
      for (int i = 0; i < 6000; i++) begin
         duty_wr = ($urandom_range(0, 39) == 0);
         duty_in = 8'($urandom);
         irq_ack = ($urandom_range(0, 24) == 0);
         rst     = ($urandom_range(0, 1999) == 0);
         if ($urandom_range(0, 299) == 0) tb_cnt = 8'($urandom);
         if ($urandom_range(0, 499) == 0)
            per_thresh = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
         run_cycle($urandom_range(0, 149) == 0);
      end
      rst = 1'b0; duty_wr = 1'b0; irq_ack = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
